// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Groups the signals between the UART TX arbiter and the rest of the
//   system, which is the byte requesters, the baud generator and the TX core.
//   The clock and reset are not part of this interface.
//   Signals:
//     i_tick      16x baud tick pulse from the baud-rate generator
//     i_req       per-requester level request
//     i_data      requester k byte in bits [k*DATA_BITS +: DATA_BITS]
//     i_tx_done   frame-complete pulse from the TX core
//     o_grant     one-hot, one-cycle acknowledge to the winning requester
//     o_tx_start  one-cycle start pulse to the TX core
//     o_tx_data   byte latched for the current frame
//     o_owner     index of the current or last granted requester
//     o_busy      arbiter is not idle
//   Modports:
//     slave       the arbiter itself
//     master      the surrounding system that drives the arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int DATA_BITS = 8
);
  localparam int OWN_BITS = $clog2(N_REQ);

  logic                       i_tick;
  logic [N_REQ-1:0]           i_req;
  logic [N_REQ*DATA_BITS-1:0] i_data;
  logic                       i_tx_done;
  logic [N_REQ-1:0]           o_grant;
  logic                       o_tx_start;
  logic [DATA_BITS-1:0]       o_tx_data;
  logic [OWN_BITS-1:0]        o_owner;
  logic                       o_busy;

  modport slave (
    input  i_tick, i_req, i_data, i_tx_done,
    output o_grant, o_tx_start, o_tx_data, o_owner, o_busy
  );

  modport master (
    output i_tick, i_req, i_data, i_tx_done,
    input  o_grant, o_tx_start, o_tx_data, o_owner, o_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Lets N_REQ byte requesters share one UART transmitter core. When the
//   arbiter is idle it picks a requester round-robin, latches that
//   requester's byte and acknowledges it with a one-cycle grant. It then
//   pulses the TX core start for one cycle and waits for the frame-done
//   pulse. After that it waits out an inter-frame gap of GAP_TICKS 16x baud
//   ticks before it arbitrates again.
//   Ports:
//     i_clock  system clock
//     i_reset  synchronous, active-high reset
//     bus      uart_tx_arbiter_if.slave, which carries the requests, data,
//              tick, tx_done, grant, tx_start, tx_data, owner and busy
//              signals
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_BITS = 8,
  parameter int GAP_TICKS = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  uart_tx_arbiter_if.slave     bus
);
  localparam int OWN_BITS = $clog2(N_REQ);
  // The counter only has to hold values up to GAP_TICKS-1. It stops at that
  // value and never wraps.
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [OWN_BITS-1:0] LAST_IDX = OWN_BITS'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t                state_reg;
  logic [OWN_BITS-1:0]   ptr_reg;
  logic [OWN_BITS-1:0]   owner_reg;
  logic [GAP_W-1:0]      gap_cnt_reg;
  logic [N_REQ-1:0]      grant_reg;
  logic                  tx_start_reg;
  logic                  busy_reg;
  logic [DATA_BITS-1:0]  tx_data_reg;

  logic [DATA_BITS-1:0]  req_byte [N_REQ];
  logic                  win_valid;
  logic [OWN_BITS-1:0]   win_idx;
  logic [OWN_BITS:0]     cand_sum;
  logic [OWN_BITS-1:0]   cand_idx;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign req_byte[gi] = bus.i_data[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  // Round-robin search. The loop scans from the farthest offset down to the
  // pointer, so the last match it records is the set bit closest to the
  // pointer going upward. Each candidate index is formed one bit wider and
  // folded back, so the wrap also works when N_REQ is not a power of two.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, ptr_reg} + (OWN_BITS+1)'(k);
      if (cand_sum >= (OWN_BITS+1)'(N_REQ))
        cand_sum = cand_sum - (OWN_BITS+1)'(N_REQ);
      cand_idx = cand_sum[OWN_BITS-1:0];
      if (bus.i_req[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      gap_cnt_reg  <= '0;
      grant_reg    <= '0;
      tx_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      // Grant and start are single-cycle pulses unless set again below.
      grant_reg    <= '0;
      tx_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            grant_reg   <= N_REQ'(1) << win_idx;
            tx_data_reg <= req_byte[win_idx];
            owner_reg   <= win_idx;
            ptr_reg     <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= START;
          end
        end
        START: begin
          tx_start_reg <= 1'b1;
          state_reg    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A tick that arrives in the same cycle as tx_done is not counted
          // toward the gap, because counting only starts in GAP.
          if (bus.i_tx_done) begin
            if (GAP_TICKS == 0) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              gap_cnt_reg <= '0;
              state_reg   <= GAP;
            end
          end
        end
        GAP: begin
          if (bus.i_tick) begin
            if (gap_cnt_reg == GAP_LAST) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_grant    = grant_reg;
  assign bus.o_tx_start = tx_start_reg;
  assign bus.o_tx_data  = tx_data_reg;
  assign bus.o_owner    = owner_reg;
  assign bus.o_busy     = busy_reg;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter core among N_REQ byte requesters, such as the debug unit's register, memory and PC dump paths.
- Arbitrates round-robin and latches the winning byte.
- Issues a single-cycle start to the TX core, then waits for frame completion.
- Enforces a programmable inter-frame gap, counted in 16x baud ticks from the baud-rate generator, before granting again.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, width of the UART data byte.
- GAP_TICKS, 16, idle 16x ticks inserted after each frame (0 = no gap; 16 = one bit time).
- OWN_BITS, $clog2(N_REQ), width of the owner index (derived localparam, not overridable).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_tick  in  1  16x baud tick, one-cycle pulse from the baud-rate generator.
- i_req  in  N_REQ  per-requester level request; held until granted.
- i_data  in  N_REQ*DATA_BITS  requester k byte in bits [k*DATA_BITS +: DATA_BITS].
- o_grant  out  N_REQ  one-hot, one-cycle acknowledge; requester k may drop or change its request next cycle.
- o_tx_start  out  1  one-cycle start pulse to the TX core.
- o_tx_data  out  DATA_BITS  latched byte; stable from the start pulse until return to IDLE.
- i_tx_done  in  1  one-cycle frame-complete pulse from the TX core.
- o_owner  out  OWN_BITS  index of the current or last granted requester.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - state=IDLE.
  - o_grant=0, o_tx_start=0, o_tx_data=0, o_owner=0, o_busy=0.
  - Round-robin pointer=0, gap counter=0.
- Reset mid-operation aborts the transaction immediately. No pending start or grant is emitted afterwards.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE:
  - If any i_req bit is set, select the first set bit searching upward from the pointer, wrapping modulo N_REQ.
  - In the same cycle, register:
    - o_tx_data = winner byte.
    - o_owner = winner.
    - o_grant = one-hot(winner) for exactly one cycle.
    - pointer = (winner+1) mod N_REQ.
  - Next state = START.
  - With no request, stay in IDLE with all outputs held.
- START: o_tx_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - Remain until i_tx_done=1.
  - Then, if GAP_TICKS==0, go to IDLE; otherwise clear the gap counter and go to GAP.
  - i_tx_done is sampled only in WAIT_DONE; pulses in any other state are ignored.
- GAP:
  - On each i_tick, increment the gap counter.
  - When an i_tick arrives with counter==GAP_TICKS-1, go to IDLE.
  - Cycles without a tick do not count.
- Grant latency:
  - Requests and the grant are registered (o_grant is set on the clock edge that samples i_req in IDLE).
  - o_tx_start follows one cycle after o_grant.
- Round-robin is fair: with all requests held, grants rotate 0,1,2,...,N_REQ-1,0.
- A request arriving while busy is serviced at the next IDLE according to the pointer.
- Requests dropped before a grant are simply not serviced. Requests raised and dropped while busy are lost (level protocol).
- Width rules:
  - The gap counter is wide enough for GAP_TICKS-1 and never wraps.
  - The pointer wraps to 0 after N_REQ-1 for non-power-of-two N_REQ.
- Simultaneous i_tick and i_tx_done in WAIT_DONE: the tick is not counted toward the gap.

Test Plan:
- Reset: hold i_reset 3 cycles with i_req=4'b1111 -> all outputs 0, no grant.
  - Release reset -> o_grant=4'b0001 on the first edge, o_tx_start one cycle later, o_tx_data=i_data[7:0].
- Single requester: req[2] with byte 0xA5 -> o_grant=4'b0100, o_owner=2, o_tx_data=0xA5, one o_tx_start pulse.
  - Pulse i_tx_done -> o_busy stays high for exactly 16 ticks, then 0.
- Fairness: all four requests held, 8 frames -> grant order 0,1,2,3,0,1,2,3. Exactly one o_tx_start per frame.
- Pointer wrap: last grant=3, then req=4'b1010 -> next grant=1. Following grant=3.
- Gap and spurious events:
  - i_tx_done pulse during GAP or START -> ignored, state unchanged.
  - i_tick coincident with i_tx_done -> the gap still needs 16 further ticks.
  - GAP_TICKS=0 build -> IDLE one cycle after done.
- Reset mid-frame: assert i_reset in WAIT_DONE -> o_busy=0 next cycle, pointer=0.
  - A later i_tx_done produces no grant. New requests are arbitrated from index 0.
